// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the audio clock-enable scheduler.
package audio_pkg;

  localparam int unsigned FRAME_LEN = 15120;

  localparam int unsigned DIV_PSG_IN = 240;
  localparam int unsigned DIV_PSG_I1 = 48;
  localparam int unsigned DIV_PSG_D1 = 144;
  localparam int unsigned DIV_SMS_IN = 1080;
  localparam int unsigned DIV_SMS_I1 = 216;
  localparam int unsigned DIV_SMS_I2 = 72;
  localparam int unsigned DIV_SMS_D1 = 504;
  localparam int unsigned DIV_FM_IN  = 1008;
  localparam int unsigned DIV_FM_I1  = 252;
  localparam int unsigned DIV_FM_I2  = 63;
  localparam int unsigned DIV_FM_I3  = 9;

  localparam int unsigned NUM_TAPS  = 11;
  localparam int unsigned TAP_FM_IN = 7;

  // Tap order matches the strobe vector: psg[2:0], sms[6:3], fm[10:7].
  localparam int unsigned TAP_DIV [NUM_TAPS] = '{
    DIV_PSG_IN, DIV_PSG_I1, DIV_PSG_D1,
    DIV_SMS_IN, DIV_SMS_I1, DIV_SMS_I2, DIV_SMS_D1,
    DIV_FM_IN, DIV_FM_I1, DIV_FM_I2, DIV_FM_I3
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN
  } state_t;

endpackage

// File: rtl/audio_cen_tap.sv
// One divider tap: down-counter reloaded at frame start; tick flags that the
// upcoming phase is a multiple of DIV so the parent can register its strobe.
module audio_cen_tap #(
  parameter int unsigned DIV = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic start,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = run & (start | (cnt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= W'(DIV - 1);
    end else if (!run || start || (cnt == '0)) begin
      cnt <= W'(DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/audio_cen_sched.sv
// Audio clock-enable scheduler: IDLE/CLEAR/RUN sequencer with a master phase
// counter and eleven phase-aligned, enable-gated divider strobes.
module audio_cen_sched #(
  parameter int unsigned CLR_CYCLES = 16,
  parameter int unsigned FRAME_LEN  = audio_pkg::FRAME_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_req,
  input  logic        psg_en,
  input  logic        smsfm_en,
  input  logic        fm_en,
  output logic        cen_psg_in,
  output logic        cen_psg_i1,
  output logic        cen_psg_d1,
  output logic        cen_sms_in,
  output logic        cen_sms_i1,
  output logic        cen_sms_i2,
  output logic        cen_sms_d1,
  output logic        cen_fm_in,
  output logic        cen_fm_i1,
  output logic        cen_fm_i2,
  output logic        cen_fm_i3,
  output logic        filt_clr,
  output logic        frame,
  output logic        busy,
  output logic [13:0] phase
);

  import audio_pkg::*;

  localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [13:0]          phase_nxt;
  logic [CW-1:0]        clr_cnt;
  logic                 psg_g, sms_g, fm_g;
  logic                 psg_gn, sms_gn, fm_gn;
  logic                 run, start, samp;
  logic [NUM_TAPS-1:0]  tick;
  logic [NUM_TAPS-1:0]  gate;
  logic [NUM_TAPS-1:0]  cen;

  always_comb begin
    state_nxt = state;
    phase_nxt = '0;
    unique case (state)
      ST_IDLE:  if (run_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == CW'(CLR_CYCLES - 1)) state_nxt = ST_RUN;
      ST_RUN: begin
        if (phase == 14'(FRAME_LEN - 1)) begin
          if (!run_req) state_nxt = ST_IDLE;
        end else begin
          phase_nxt = phase + 14'd1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered, so taps and gates are evaluated for the next phase.
  assign run   = (state_nxt == ST_RUN);
  assign start = run && (phase_nxt == '0);
  assign samp  = tick[TAP_FM_IN];

  assign psg_gn = samp ? psg_en   : psg_g;
  assign sms_gn = samp ? smsfm_en : sms_g;
  assign fm_gn  = samp ? fm_en    : fm_g;

  // The mix path runs on the FM chain, so any active source keeps FM strobing.
  assign gate = {{4{fm_gn | psg_gn | sms_gn}}, {4{sms_gn}}, {3{psg_gn}}};

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    audio_cen_tap #(.DIV(TAP_DIV[i])) u_tap (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .start (start),
      .tick  (tick[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      phase    <= '0;
      clr_cnt  <= '0;
      psg_g    <= 1'b0;
      sms_g    <= 1'b0;
      fm_g     <= 1'b0;
      cen      <= '0;
      frame    <= 1'b0;
      busy     <= 1'b0;
      filt_clr <= 1'b1;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      clr_cnt  <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      psg_g    <= psg_gn;
      sms_g    <= sms_gn;
      fm_g     <= fm_gn;
      cen      <= tick & gate;
      frame    <= start;
      busy     <= (state_nxt != ST_IDLE);
      filt_clr <= !run;
    end
  end

  assign cen_psg_in = cen[0];
  assign cen_psg_i1 = cen[1];
  assign cen_psg_d1 = cen[2];
  assign cen_sms_in = cen[3];
  assign cen_sms_i1 = cen[4];
  assign cen_sms_i2 = cen[5];
  assign cen_sms_d1 = cen[6];
  assign cen_fm_in  = cen[7];
  assign cen_fm_i1  = cen[8];
  assign cen_fm_i2  = cen[9];
  assign cen_fm_i3  = cen[10];

endmodule

// File: tb/tb_audio_cen_sched.sv
// Scoreboard bench for audio_cen_sched: stimulus queues expected strobe events
// and status probes; a negedge monitor pops and compares them.
module tb_audio_cen_sched;

  logic        clk = 1'b0;
  logic        reset, run_req, psg_en, smsfm_en, fm_en;
  logic        cen_psg_in, cen_psg_i1, cen_psg_d1;
  logic        cen_sms_in, cen_sms_i1, cen_sms_i2, cen_sms_d1;
  logic        cen_fm_in, cen_fm_i1, cen_fm_i2, cen_fm_i3;
  logic        filt_clr, frame, busy;
  logic [13:0] phase;
  logic [10:0] cen_v;

  always #5 clk = ~clk;

  audio_cen_sched #(.CLR_CYCLES(16), .FRAME_LEN(15120)) dut (
    .clk(clk), .reset(reset), .run_req(run_req),
    .psg_en(psg_en), .smsfm_en(smsfm_en), .fm_en(fm_en),
    .cen_psg_in(cen_psg_in), .cen_psg_i1(cen_psg_i1), .cen_psg_d1(cen_psg_d1),
    .cen_sms_in(cen_sms_in), .cen_sms_i1(cen_sms_i1), .cen_sms_i2(cen_sms_i2),
    .cen_sms_d1(cen_sms_d1),
    .cen_fm_in(cen_fm_in), .cen_fm_i1(cen_fm_i1), .cen_fm_i2(cen_fm_i2),
    .cen_fm_i3(cen_fm_i3),
    .filt_clr(filt_clr), .frame(frame), .busy(busy), .phase(phase)
  );

  assign cen_v = {cen_fm_i3, cen_fm_i2, cen_fm_i1, cen_fm_in,
                  cen_sms_d1, cen_sms_i2, cen_sms_i1, cen_sms_in,
                  cen_psg_d1, cen_psg_i1, cen_psg_in};

  localparam int FL = 15120;
  localparam int DIVS    [11] = '{240, 48, 144, 1080, 216, 72, 504, 1008, 252, 63, 9};
  localparam int EXP_CNT [11] = '{63, 315, 105, 14, 70, 210, 30, 15, 60, 240, 1680};

  typedef struct { int ph; logic [10:0] cen; logic fr; } ev_t;
  typedef struct { string nm; int sel; int exp; } probe_t;

  ev_t    exp_q[$];
  probe_t probe_q[$];
  int     checks = 0;
  int     failures = 0;
  int     cnt [12] = '{default: 0};
  int     last_ph = -1;
  int     ph = 0;
  probe_t pr;
  ev_t    ev;
  int     act;

  // Probe selectors: 0..10 strobe counts, 11 frame count, 12 busy, 13 filt_clr,
  // 14 phase, 15 strobe vector, 16 frame, 17 last strobe phase, 18 pending events.
  function automatic int mon_value(int sel);
    if (sel < 12) return cnt[sel];
    case (sel)
      12: return int'(busy);
      13: return int'(filt_clr);
      14: return int'(phase);
      15: return int'(cen_v);
      16: return int'(frame);
      17: return last_ph;
      default: return exp_q.size();
    endcase
  endfunction

  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      pr  = probe_q.pop_front();
      act = mon_value(pr.sel);
      checks++;
      if (act != pr.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", pr.nm, act, pr.exp);
      end
    end
    if (cen_v != '0 || frame) begin
      last_ph = int'(phase);
      for (int i = 0; i < 11; i++) if (cen_v[i]) cnt[i]++;
      if (frame) cnt[11]++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: phase=%0d cen=%03h frame=%0b with nothing expected",
                 phase, cen_v, frame);
      end else begin
        ev = exp_q.pop_front();
        if (int'(phase) != ev.ph || cen_v != ev.cen || frame != ev.fr) begin
          failures++;
          $display("FAIL sb_event: got phase=%0d cen=%03h frame=%0b expected phase=%0d cen=%03h frame=%0b",
                   phase, cen_v, frame, ev.ph, ev.cen, ev.fr);
        end
      end
    end
  end

  function automatic logic [10:0] model(int p, bit pg, bit sg, bit fg);
    logic [10:0] m;
    m = '0;
    for (int i = 0; i < 11; i++) begin
      bit g;
      g = (i < 3) ? pg : (i < 7) ? sg : (fg | pg | sg);
      m[i] = g && ((p % DIVS[i]) == 0);
    end
    return m;
  endfunction

  task automatic push_win(input int lo, input int hi, input bit pg, input bit sg, input bit fg);
    logic [10:0] c;
    for (int p = lo; p <= hi; p++) begin
      c = model(p, pg, sg, fg);
      if (c != '0 || p == 0) exp_q.push_back('{p, c, (p == 0)});
    end
  endtask

  task automatic probe(input string nm, input int sel, input int ex);
    probe_q.push_back('{nm, sel, ex});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (ph < target) begin
      step();
      ph++;
    end
  endtask

  initial begin
    reset = 1'b1; run_req = 1'b0; psg_en = 1'b0; smsfm_en = 1'b0; fm_en = 1'b0;
    repeat (3) step();
    probe("rst_phase", 14, 0);
    probe("rst_busy", 12, 0);
    probe("rst_filt_clr", 13, 1);
    probe("rst_cen", 15, 0);
    probe("rst_frame", 16, 0);
    step();
    reset = 1'b0;
    step();
    probe("idle_busy", 12, 0);
    probe("idle_filt_clr", 13, 1);
    probe("idle_phase", 14, 0);

    // Cycle 0: request run with every source enabled; frame 1 fully enabled.
    psg_en = 1'b1; smsfm_en = 1'b1; fm_en = 1'b1; run_req = 1'b1;
    push_win(0, FL - 1, 1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step();
      probe($sformatf("clear_filt_clr_c%0d", c), 13, 1);
      probe($sformatf("clear_busy_c%0d", c), 12, 1);
    end
    step();
    probe("run_filt_clr", 13, 0);
    probe("first_run_cen", 15, 'h7FF);
    probe("first_run_frame", 16, 1);
    probe("first_run_phase", 14, 0);

    ph = 0;
    run_to(FL);
    for (int i = 0; i < 11; i++) probe($sformatf("count_div%0d", DIVS[i]), i, EXP_CNT[i]);
    probe("frame_count", 11, 1);

    // Frame 2: psg off at 500 (sampled at 1008), then psg on / sms, fm off at
    // 1100 (sampled at 2016, fm kept alive by psg); run_req drops at 3000.
    push_win(0, 1007, 1'b1, 1'b1, 1'b1);
    push_win(1008, 2015, 1'b0, 1'b1, 1'b1);
    push_win(2016, FL - 1, 1'b1, 1'b0, 1'b0);
    run_to(FL + 500);
    psg_en = 1'b0;
    run_to(FL + 1100);
    psg_en = 1'b1; smsfm_en = 1'b0; fm_en = 1'b0;
    run_to(FL + 3000);
    run_req = 1'b0;
    run_to(2 * FL - 1);
    probe("end_phase", 14, FL - 1);
    probe("end_busy", 12, 1);
    step();
    probe("stop_busy", 12, 0);
    probe("stop_filt_clr", 13, 1);
    probe("stop_phase", 14, 0);
    probe("last_strobe_phase", 17, 15111);
    probe("frame2_drained", 18, 0);
    repeat (3) step();

    // Second run, interrupted by an asynchronous reset at phase 7000.
    psg_en = 1'b1; smsfm_en = 1'b1; fm_en = 1'b1; run_req = 1'b1;
    push_win(0, 6999, 1'b1, 1'b1, 1'b1);
    repeat (17) step();
    probe("rerun_phase", 14, 0);
    repeat (6999) step();
    probe("pre_reset_phase", 14, 6999);
    step();
    #2;
    reset = 1'b1;
    run_req = 1'b0;
    #1;
    probe("async_cen", 15, 0);
    probe("async_phase", 14, 0);
    probe("async_busy", 12, 0);
    probe("async_filt_clr", 13, 1);
    probe("async_frame", 16, 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    probe("post_reset_busy", 12, 0);
    probe("rerun_drained", 18, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
